// File: rtl/neuron_mac_seq_pkg.sv
// Shared width defaults and FSM state type for the sequential neuron.
package neuron_pkg;
    localparam int PIX_W_DEF = 9;
    localparam int W_W_DEF   = 8;
    localparam int ACC_W_DEF = 32;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;
endpackage

// File: rtl/neuron_mac_seq_if.sv
// Operand stream and result port of neuron_mac_seq; master drives operands, slave is the neuron.
interface neuron_mac_seq_if
    import neuron_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [PIX_W-1:0] pixel;
    logic signed [W_W-1:0]   weight;
    logic signed [W_W-1:0]   bias;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;

    modport master (
        output in_valid, pixel, weight, bias, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, pixel, weight, bias, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/neuron_mac_seq_mac.sv
// Combinational multiply-accumulate: acc + sign-extended full-width pixel*weight.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [PIX_W-1:0] pixel_i,
    input  logic signed [W_W-1:0]   weight_i,
    output logic signed [ACC_W-1:0] sum_o
);
    logic signed [PIX_W+W_W-1:0] prod;

    assign prod  = pixel_i * weight_i;
    assign sum_o = acc_i + ACC_W'(prod);
endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: one MAC per accepted beat, bias on the last beat, valid/ready result.
// Optional NEURON_RELU_EN clamps negative results to zero.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 256,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int W_W      = W_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    neuron_mac_seq_if.slave bus
);
    localparam int             CNT_W    = $clog2(N_INPUTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_q, out_d;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] result;
    logic                    beat;

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
        return x[ACC_W-1] ? '0 : x;
    endfunction

    neuron_mac #(
        .PIX_W (PIX_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .acc_i    (acc_q),
        .pixel_i  (bus.pixel),
        .weight_i (bus.weight),
        .sum_o    (mac_sum)
    );

    assign beat   = bus.in_valid && (state_q == ACCUM);
    assign biased = mac_sum + ACC_W'(bus.bias);

`ifdef NEURON_RELU_EN
    assign result = relu(biased);
`else
    assign result = biased;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            ACCUM: begin
                if (beat) begin
                    if (cnt_q == CNT_LAST) begin
                        out_d   = result;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = mac_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // Result stays frozen until the consumer takes it.
                if (bus.out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state_q == HOLD) || (cnt_q != '0);
endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequential, parametrised successor to the fully combinational 256-input neuron. It streams one (pixel, weight) pair per accepted beat through a single signed multiply-accumulate unit, adds a signed bias after the last of N_INPUTS beats, and presents the result on a valid/ready output port. It sits between the image/weight memory sequencer and the layer-output buffer of the inference datapath.

## Interface
- N_INPUTS, 256: operands per dot product; must be ≥ 2.
- PIX_W, 9: signed pixel width.
- W_W, 8: signed weight width; bias uses the same width.
- ACC_W, 32: signed accumulator and output width; must be ≥ PIX_W+W_W.
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: pixel/weight pair offered.
- in_ready, output, 1: block accepts a pair this cycle.
- pixel, input, PIX_W: signed pixel.
- weight, input, W_W: signed weight.
- bias, input, W_W: signed bias; sampled only on the last input beat.
- out_valid, output, 1: out_data holds a valid result.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, ACC_W: signed neuron result.
- busy, output, 1: at least one beat of the current dot product has been accepted.

## Operation
- The FSM has two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
- Beat: in_valid && in_ready. Each beat computes prod = pixel*weight as a signed full-width product, sign-extended to ACC_W.
- Non-last beat (cnt < N_INPUTS-1): acc <= acc + prod; cnt <= cnt + 1.
- Last beat (cnt == N_INPUTS-1): out_data <= acc + prod + sext(bias); acc <= 0; cnt <= 0; state <= HOLD.
- All accumulator arithmetic wraps modulo 2^ACC_W in two's complement. There is no saturation.
- HOLD: out_data and out_valid stay stable until out_valid && out_ready. On that cycle the FSM returns to ACCUM.
- busy = (cnt != 0) in ACCUM, and 1 in HOLD.
- A cycle without a beat in ACCUM leaves acc and cnt unchanged. Gaps between beats are allowed.
- Reset (rst_n=0, sampled on a clk edge), including mid-accumulation or during HOLD: state=ACCUM, acc=0, cnt=0, out_data=0, out_valid=0. A partial sum is discarded.
- Reset values of outputs: in_ready=1 (after reset is released), out_valid=0, out_data=0, busy=0.
- The counter width is $clog2(N_INPUTS).

## Timing
- Latency: the last beat is accepted at edge t, and out_valid=1 with the result from edge t (visible in cycle t+1).
- Throughput: N_INPUTS beats plus at least one HOLD cycle per result. in_ready is low during every HOLD cycle, including the handshake cycle. The next beat can be accepted no earlier than the cycle after out_ready is seen.
- in_ready depends only on the state. It never depends combinationally on in_valid. out_valid is registered.
- If out_ready stays low, HOLD persists indefinitely (backpressure). in_ready stays 0 throughout.

## Configuration
- NEURON_RELU_EN defined: the value written to out_data on the last beat is max(0, acc+prod+bias), so negative results become 0.
- NEURON_RELU_EN undefined: out_data is the raw signed sum.
- Timing and handshake behaviour are identical in both builds.

## Structure
- Shared package neuron_pkg holds:
  - default width constants (PIX_W_DEF=9, W_W_DEF=8, ACC_W_DEF=32);
  - typedef state_t {ACCUM, HOLD}.
- Sub-module neuron_mac is purely combinational: it takes acc, pixel, weight and returns acc + sext(pixel*weight). The top level holds the FSM, counter and output register, and instantiates neuron_mac once.

## Test plan
- All-ones stream, N_INPUTS=256: pixel=1, weight=1, bias=0 on 256 back-to-back beats → out_data=256, out_valid rises exactly one cycle after the 256th beat.
- Negative bias and ReLU check: pixel=-1, weight=5 over 4 beats with N_INPUTS=4, bias=-3 → out_data=-23 without NEURON_RELU_EN, and 0 with it.
- Backpressure: hold out_ready=0 for 10 cycles after the result appears → out_data stable, in_ready=0 throughout. Assert out_ready → next cycle out_valid=0, in_ready=1.
- Gapped input: in_valid toggles 1/0 over 8 beats (N_INPUTS=8) with pixel=2, weight=3, bias=1 → out_data=49, and busy=1 from the first beat until the handshake.
- Reset mid-operation: drive rst_n=0 after 100 of 256 beats, then run 256 beats of pixel=-256, weight=-128, bias=127 → out_data=8388735, with no residue from the aborted sum.
- Wrap-around with ACC_W=17, N_INPUTS=4: pixel=255, weight=127 on each beat, bias=0 → out_data equals 129540 mod 2^17, interpreted as signed (-1532).
